// File: rtl/motor_cntrl_pkg.sv
// rtl/motor_cntrl_pkg.sv - shared widths, full-scale constant and command saturation for motor_cntrl_n
package motor_cntrl_pkg;

    localparam int DEF_IN_W = 11;

    function automatic int mag_width(input int in_w);
        return in_w - 1;
    endfunction

    function automatic int mag_max(input int mag_w);
        return (1 << mag_w) - 1;
    endfunction

    // The single asymmetric two's-complement value folds onto -MAX so |cmd| always fits MAG_W bits.
    function automatic int sat_cmd(input int v, input int mag_w);
        if (v == -(1 << mag_w))
            return -((1 << mag_w) - 1);
        return v;
    endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// rtl/motor_ramp_chan.sv - one H-bridge channel: target, slew (MOTOR_SLEW_EN), PWM outputs, at_target
module motor_ramp_chan
    import motor_cntrl_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int SLEW_STEP = 64,
    localparam int MAG_W    = mag_width(IN_W)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [IN_W-1:0] cmd,
    input  logic                   cmd_vld,
    input  logic                   brake,
    input  logic [MAG_W-1:0]       cnt,
    input  logic                   boundary,
    output logic                   fwd,
    output logic                   rev,
    output logic                   at_target
);

    typedef logic signed [IN_W-1:0] cmd_t;

    cmd_t             target_q;
    cmd_t             current_q;
    cmd_t             current_d;
    cmd_t             ramp_val;
    logic [IN_W-1:0]  mag_full;
    logic             pos;
    logic             pwm_on;

`ifdef MOTOR_SLEW_EN
    localparam logic [IN_W:0]   STEP_U = (IN_W+1)'(SLEW_STEP);
    localparam cmd_t            STEP_N = IN_W'(SLEW_STEP);
    logic signed [IN_W:0]       diff;
    logic [IN_W:0]              diff_mag;
`endif

    always_comb begin
        ramp_val = target_q;
`ifdef MOTOR_SLEW_EN
        diff     = {target_q[IN_W-1], target_q} - {current_q[IN_W-1], current_q};
        diff_mag = diff[IN_W] ? -diff : diff;
        // A step never overshoots, so the result stays within +/-MAX and fits IN_W bits.
        if (diff_mag > STEP_U)
            ramp_val = diff[IN_W] ? current_q - STEP_N : current_q + STEP_N;
`endif
    end

    always_comb begin
        current_d = current_q;
        if (brake)
            current_d = '0;
        else if (boundary)
            current_d = ramp_val;
    end

    always_comb begin
        pos      = ~current_q[IN_W-1];
        mag_full = pos ? current_q : -current_q;
        pwm_on   = {1'b0, cnt} < mag_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q  <= '0;
            current_q <= '0;
            fwd       <= 1'b0;
            rev       <= 1'b0;
            at_target <= 1'b1;
        end else begin
            if (cmd_vld)
                target_q <= IN_W'(sat_cmd(int'(cmd), MAG_W));
            current_q <= current_d;
            fwd       <= brake | (pos & pwm_on);
            rev       <= brake | (~pos & pwm_on);
            at_target <= (current_q == target_q);
        end
    end

endmodule

// File: rtl/motor_cntrl_n.sv
// rtl/motor_cntrl_n.sv - N-channel H-bridge PWM controller with shared period counter (MOTOR_SLEW_EN enables ramping)
module motor_cntrl_n
    import motor_cntrl_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int IN_W      = DEF_IN_W,
    parameter int SLEW_STEP = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*IN_W-1:0]   cmd,
    input  logic                  cmd_vld,
    input  logic                  brake,
    output logic [NCH-1:0]        fwd,
    output logic [NCH-1:0]        rev,
    output logic [NCH-1:0]        at_target
);

    localparam int MAG_W = mag_width(IN_W);
    localparam int MAX   = mag_max(MAG_W);

    typedef logic signed [IN_W-1:0] cmd_t;

    logic [MAG_W-1:0] cnt;
    logic             boundary;

    // Period is MAX cycles so that a magnitude of MAX means continuously on.
    assign boundary = (cnt == MAG_W'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (boundary)
            cnt <= '0;
        else
            cnt <= cnt + MAG_W'(1);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        cmd_t chan_cmd;
        assign chan_cmd = cmd[i*IN_W +: IN_W];

        motor_ramp_chan #(
            .IN_W      (IN_W),
            .SLEW_STEP (SLEW_STEP)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd       (chan_cmd),
            .cmd_vld   (cmd_vld),
            .brake     (brake),
            .cnt       (cnt),
            .boundary  (boundary),
            .fwd       (fwd[i]),
            .rev       (rev[i]),
            .at_target (at_target[i])
        );
    end

endmodule

// File: doc/motor_cntrl_n.md
Name: motor_cntrl_n

Overview:
Parametrised N-channel H-bridge drive controller. Each channel takes a signed speed command and produces registered fwd/rev PWM outputs. Channels share one period counter. Each channel has per-period slew limiting, magnitude saturation and a global brake mode. It sits between the motion/PID layer and the motor driver pins, and replaces the fixed 2-channel, 11-bit, unramped controller.

Parameters:
NCH, 2, number of motor channels
IN_W, 11, signed command width; magnitude width MAG_W = IN_W-1
SLEW_STEP, 64, maximum change in |current| per PWM period (used only with ramping compiled in)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd  in  NCH*IN_W  packed signed commands; channel i occupies bits [i*IN_W +: IN_W]
cmd_vld  in  1  when high, all NCH targets are captured from cmd on this clock edge
brake  in  1  level-sensitive global brake
fwd  out  NCH  forward PWM per channel, registered
rev  out  NCH  reverse PWM per channel, registered
at_target  out  NCH  per-channel flag, high when current == target, registered

Behaviour:
- Reset is asynchronous, active-low; clock is clk. On reset: fwd=0, rev=0, at_target=all 1; every target and current = 0; period counter cnt = 0.
- Let MAX = 2^MAG_W - 1. cnt is MAG_W bits wide and free-runs 0..MAX-1, then wraps to 0; the period is MAX cycles. The boundary cycle is cnt == MAX-1.
- Target capture: on a cmd_vld edge, target[i] = sat(cmd[i]). sat maps -2^MAG_W to -MAX; all other values pass unchanged.
- Current update happens only on the boundary edge, using the target as it stood before that edge.
  - A cmd_vld on the boundary cycle takes effect at the following boundary.
  - Compute diff = target - current at IN_W+1 bits.
  - If |diff| <= SLEW_STEP: current = target.
  - Otherwise: current = current ± SLEW_STEP, toward target.
  - current may cross zero in a single step; no overshoot of target is allowed.
- Output register, per channel, with mag = |current| and pos = (current >= 0):
  - fwd <= pos & (cnt < mag)
  - rev <= ~pos & (cnt < mag)
  - At most one of fwd/rev is high outside brake.
  - mag 0 gives a 0% duty cycle; mag MAX gives 100% (continuously high).
  - Output latency is one cycle from cnt.
- Brake (takes priority):
  - While brake=1: fwd=rev=all 1 from the next edge, current forced to 0 every cycle, and cnt keeps running.
  - Targets are still captured on cmd_vld during brake.
  - On release, ramping resumes from 0 at the next boundary.
- at_target[i] <= (current[i] == target[i]). This is evaluated every cycle.
- A reset mid-period clears everything immediately, without waiting for a clock edge.

Optional Feature:
MOTOR_SLEW_EN
- Defined: slew limiting applies as described above.
- Undefined: at each boundary, current = target directly; the SLEW_STEP parameter is ignored. at_target can therefore lag by at most one period.

Decomposition:
- Package motor_cntrl_pkg holds:
  - MAG_W derivation
  - the MAX constant and the saturation function
  - a signed command typedef, parametrised through localparams in the top
- One natural sub-module, motor_ramp_chan, instantiated NCH times from a generate loop. It covers target register, saturation, slew, output flops and at_target.
- The shared cnt stays in the top level.

Test Plan (NCH=2, IN_W=11, MAX=1023, SLEW_STEP=64, MOTOR_SLEW_EN defined):
1. Assert rst_n low mid-run -> fwd=rev=00 and at_target=11 immediately; cnt restarts at 0 after release.
2. cmd ch0=+512 with cmd_vld -> current steps 64, 128, … 512 over 8 boundaries; then fwd[0] high for exactly 512 of every 1023 cycles, rev[0]=0, at_target[0]=1.
3. cmd ch1=-1024 -> target clamped to -1023; after 16 boundaries rev[1] is continuously high, fwd[1] is never high.
4. ch0 moves from +100 to -100 -> current sequence 36, -28, -92, -100; fwd[0]&rev[0] is never 1.
5. brake pulse mid-ramp -> fwd=rev=11 on the next edge; after release, current restarts from 0 and ramps to the retained target.
6. cmd_vld on the boundary cycle (cnt=1022) -> the new target is not applied until the next boundary; with MOTOR_SLEW_EN undefined, the ch0 jump 0→+1000 completes in one period.
